expu_row_accumulator: RTL and testbench
=======================================

// Module: expu_row_accumulator
// PURPOSE
//  Downstream stage of the exponential unit: consumes its non-negative FP results (default BF16)
//  over a valid/ready stream and sums each row in unsigned fixed point (softmax denominator).
//  A row ends on the beat tagged last_i; the row sum and element count are then held with a
//  valid/ready output handshake until taken. Sits between the exp pipeline and the normaliser.
// PARAMETERS
//  FPFORMAT   FP16ALT  input float format; WIDTH/MANTISSA_BITS/EXPONENT_BITS derive from it
//  ACC_WIDTH  32       accumulator width, unsigned fixed point
//  ACC_FRAC   16       fractional bits of accumulator
//  CNT_WIDTH  16       element counter width
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_i        in   1          asynchronous active-high reset
//  clear_i      in   1          synchronous clear, highest priority after reset
//  valid_i      in   1          input beat valid
//  ready_o      out  1          input beat accepted when valid_i & ready_o
//  op_i         in   WIDTH      FP operand from exp unit; sign bit ignored (always 0)
//  last_i       in   1          accepted beat is final element of the row
//  sum_valid_o  out  1          row result valid
//  sum_ready_i  in   1          downstream takes result when sum_valid_o & sum_ready_i
//  sum_o        out  ACC_WIDTH  row sum, ACC_FRAC fractional bits
//  count_o      out  CNT_WIDTH  elements in the row
//  ovf_o        out  1          sticky: sum saturated/wrapped during this row
// BEHAVIOUR
//  Reset: rst_i async, active-high; state=IDLE, acc/count/ovf=0, sum_valid_o=0, ready_o=1 after release.
//  Conversion: exp field 0 -> value 0 (denormals flushed); else {1,mant} shifted by
//   e = exp - bias + ACC_FRAC - MANTISSA_BITS; e<0 right shift truncating; result not fitting
//   ACC_WIDTH -> all-ones and sets ovf. Exp field all-ones (inf/NaN) -> all-ones, sets ovf.
//  FSM: IDLE -> ACC on accepted non-last beat (acc=conv, count=1); IDLE -> HOLD on accepted
//   last beat (single-element row). ACC: acc+=conv, count+=1 per accepted beat; last -> HOLD.
//   HOLD: sum_valid_o=1, ready_o=0; on sum_ready_i -> IDLE, acc/count/ovf cleared.
//  ready_o = (state != HOLD); combinational from state only, never from valid_i.
//  Latency: sum_valid_o rises the cycle after the last beat is accepted; sum_o/count_o/ovf_o
//   stable while sum_valid_o=1, value of accumulator otherwise (don't care).
//  Adder overflow: see CONFIGURATION. Counter saturates at all-ones (no wrap).
//  clear_i: next state IDLE, acc/count/ovf=0, sum_valid_o=0; pending result discarded; any
//   beat presented in the same cycle is dropped.
//  No bubbles required: back-to-back beats every cycle in IDLE/ACC; one dead input cycle after
//   HOLD is exited (ready_o rises in the cycle after the handshake).
// CONFIGURATION
//  `EXPU_ACC_SATURATE_EN defined: adder carry-out -> acc clamps to all-ones, ovf_o set.
//  Undefined: adder wraps modulo 2^ACC_WIDTH, ovf_o still set on carry-out.
//  Converter overflow saturates in both builds.
// STRUCTURE
//  expu_pkg: typedef enum acc_state_e {ACC_IDLE, ACC_RUN, ACC_HOLD}; function fp_bias(exp_bits).
//  Sub-module expu_fp2fix: combinational FP->fixed converter (op_i -> value, ovf), params FPFORMAT,
//   ACC_WIDTH, ACC_FRAC. Top holds FSM, accumulator, counter, flags.
// TESTING (FPFORMAT=FP16ALT, ACC_WIDTH=32, ACC_FRAC=16)
//  1.0,1.0,0.5(last): 0x3F80,0x3F80,0x3F00 -> sum_o=0x0002_8000, count_o=3, ovf_o=0, 1 cycle late.
//  Single beat 0x3F80 last with sum_ready_i=0 for 5 cycles -> held 0x0001_0000, ready_o=0 throughout.
//  0x0000 and 0x0001 (denormal), last -> sum_o=0, count_o=2; 0x3380 (2^-24) -> contributes 0.
//  0x4700,0x4700(last) (2^15 each) -> SATURATE_EN: 0xFFFF_FFFF, ovf=1; else 0x0000_0000, ovf=1.
//  0x7F80 (inf) last -> sum_o=0xFFFF_FFFF, ovf_o=1 in both builds.
//  clear_i mid-row after two 0x3F80, then 0x3F00(last) -> sum_o=0x0000_8000, count_o=1;
//   rst_i pulsed in HOLD -> sum_valid_o=0 immediately, ready_o=1.

Source files
------------

// File: rtl/expu_pkg.sv
// Shared types and helpers for the exponential-unit downstream stages:
// float format selector, row-accumulator FSM states and FP field geometry.
package expu_pkg;

   typedef enum logic [1:0] {
      FP32,
      FP16,
      FP8,
      FP16ALT
   } fp_format_e;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_RUN,
      ACC_HOLD
   } acc_state_e;

   function automatic int fp_exp_bits(fp_format_e fmt);
      case (fmt)
         FP32:    return 8;
         FP16:    return 5;
         FP8:     return 5;
         FP16ALT: return 8;
         default: return 8;
      endcase
   endfunction

   function automatic int fp_man_bits(fp_format_e fmt);
      case (fmt)
         FP32:    return 23;
         FP16:    return 10;
         FP8:     return 2;
         FP16ALT: return 7;
         default: return 7;
      endcase
   endfunction

   function automatic int fp_width(fp_format_e fmt);
      return 1 + fp_exp_bits(fmt) + fp_man_bits(fmt);
   endfunction

   function automatic int fp_bias(int exp_bits);
      return (1 << (exp_bits - 1)) - 1;
   endfunction

endpackage

// File: rtl/expu_fp2fix.sv
// Combinational FP -> unsigned fixed-point converter. Denormals flush to zero,
// negative shifts truncate, and values that do not fit (or inf/NaN) saturate
// to all-ones with ovf raised. The sign bit is ignored.
module expu_fp2fix
   import expu_pkg::*;
#(
   parameter fp_format_e FPFORMAT  = FP16ALT,
   parameter int         ACC_WIDTH = 32,
   parameter int         ACC_FRAC  = 16
) (
   input  logic [fp_width(FPFORMAT)-1:0] op,
   output logic [ACC_WIDTH-1:0]          value,
   output logic                          ovf
);

   localparam int EXP_BITS = fp_exp_bits(FPFORMAT);
   localparam int MAN_BITS = fp_man_bits(FPFORMAT);
   localparam int WIDTH    = fp_width(FPFORMAT);
   localparam int SIG_BITS = MAN_BITS + 1;
   localparam int BIAS     = fp_bias(EXP_BITS);

   logic [EXP_BITS-1:0] exp_field;
   logic [MAN_BITS-1:0] man_field;
   logic [SIG_BITS-1:0] sig;
   logic                sign_unused;
   int                  shift;

   assign exp_field   = op[WIDTH-2 -: EXP_BITS];
   assign man_field   = op[MAN_BITS-1:0];
   assign sig         = {1'b1, man_field};
   assign sign_unused = op[WIDTH-1];

   // Align the significand to the accumulator's binary point, saturating on overflow.
   always_comb begin
      value = '0;
      ovf   = 1'b0;
      shift = int'(exp_field) - BIAS + ACC_FRAC - MAN_BITS;
      if (exp_field == '1) begin
         value = '1;
         ovf   = 1'b1;
      end else if (exp_field != '0) begin
         if (shift < 0) begin
            value = ACC_WIDTH'(sig >> (-shift));
         end else if (shift > ACC_WIDTH - SIG_BITS) begin
            value = '1;
            ovf   = 1'b1;
         end else begin
            value = ACC_WIDTH'(sig) << shift;
         end
      end
   end

endmodule

// File: rtl/expu_row_accumulator.sv
// Row accumulator for exp-unit results (softmax denominator). Sums each row in
// unsigned fixed point and holds sum/count/ovf behind a valid/ready handshake.
// Build option: EXPU_ACC_SATURATE_EN clamps the adder on carry-out; otherwise
// the adder wraps. ovf_o is raised on carry-out in both builds.
module expu_row_accumulator
   import expu_pkg::*;
#(
   parameter fp_format_e FPFORMAT  = FP16ALT,
   parameter int         ACC_WIDTH = 32,
   parameter int         ACC_FRAC  = 16,
   parameter int         CNT_WIDTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clear_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [fp_width(FPFORMAT)-1:0] op_i,
   input  logic                          last_i,
   output logic                          sum_valid_o,
   input  logic                          sum_ready_i,
   output logic [ACC_WIDTH-1:0]          sum_o,
   output logic [CNT_WIDTH-1:0]          count_o,
   output logic                          ovf_o
);

   acc_state_e           state, state_next;
   logic [ACC_WIDTH-1:0] acc, acc_next, acc_base, conv;
   logic [ACC_WIDTH:0]   sum_ext;
   logic [CNT_WIDTH-1:0] count, count_next;
   logic                 ovf, ovf_next, conv_ovf, carry, accept;

   expu_fp2fix #(
      .FPFORMAT  (FPFORMAT),
      .ACC_WIDTH (ACC_WIDTH),
      .ACC_FRAC  (ACC_FRAC)
   ) u_fp2fix (
      .op    (op_i),
      .value (conv),
      .ovf   (conv_ovf)
   );

   assign accept = valid_i & ready_o;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ACC_IDLE;
      else       state <= state_next;
   end

   // Next-state decode and handshake outputs; ready depends on state only.
   always_comb begin
      state_next  = state;
      ready_o     = 1'b1;
      sum_valid_o = 1'b0;
      case (state)
         ACC_IDLE: if (accept) state_next = last_i ? ACC_HOLD : ACC_RUN;
         ACC_RUN:  if (accept && last_i) state_next = ACC_HOLD;
         ACC_HOLD: begin
            ready_o     = 1'b0;
            sum_valid_o = 1'b1;
            if (sum_ready_i) state_next = ACC_IDLE;
         end
         default:  state_next = ACC_IDLE;
      endcase
      if (clear_i) state_next = ACC_IDLE;
   end

   // Next accumulator/counter/flag values for an accepted beat; a row's first beat starts from zero.
   always_comb begin
      acc_base = (state == ACC_IDLE) ? '0 : acc;
      sum_ext  = {1'b0, acc_base} + {1'b0, conv};
      carry    = sum_ext[ACC_WIDTH];
`ifdef EXPU_ACC_SATURATE_EN
      acc_next = carry ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
      acc_next = sum_ext[ACC_WIDTH-1:0];
`endif
      if (state == ACC_IDLE)  count_next = CNT_WIDTH'(1);
      else if (count == '1)   count_next = count;
      else                    count_next = count + CNT_WIDTH'(1);
      ovf_next = ((state == ACC_IDLE) ? 1'b0 : ovf) | conv_ovf | carry;
   end

   // Datapath registers: clear and result hand-off zero them, accepted beats update them.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (clear_i || (state == ACC_HOLD && sum_ready_i)) begin
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (accept) begin
         acc   <= acc_next;
         count <= count_next;
         ovf   <= ovf_next;
      end
   end

   assign sum_o   = acc;
   assign count_o = count;
   assign ovf_o   = ovf;

endmodule

// File: tb/tb_expu_row_accumulator.sv
module tb_expu_row_accumulator;
   import expu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i, clear_i, valid_i, last_i, sum_ready_i;
   logic [15:0] op_i;
   logic        ready_o, sum_valid_o, ovf_o;
   logic [31:0] sum_o;
   logic [15:0] count_o;

   int tests  = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] sum;
      logic [15:0] cnt;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [3:0][15:0] ops;
      int               n;
      res_t             res;
   } vec_t;

   res_t sb[$];
   vec_t tbl[10];

   expu_row_accumulator #(
      .FPFORMAT  (FP16ALT),
      .ACC_WIDTH (32),
      .ACC_FRAC  (16),
      .CNT_WIDTH (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .op_i        (op_i),
      .last_i      (last_i),
      .sum_valid_o (sum_valid_o),
      .sum_ready_i (sum_ready_i),
      .sum_o       (sum_o),
      .count_o     (count_o),
      .ovf_o       (ovf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] o0, o1, o2, o3, input int n,
                               input logic [31:0] s, input logic [15:0] c, input logic v);
      vec_t r;
      r.ops = {o3, o2, o1, o0};
      r.n   = n;
      r.res = '{sum: s, cnt: c, ovf: v};
      return r;
   endfunction

   // Scoreboard: compare every taken result against the oldest expected one.
   always @(negedge clk) begin
      if (sum_valid_o && sum_ready_i) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_result", 32'd1, 32'd0);
         end else begin
            res_t e;
            e = sb.pop_front();
            check("sb_sum", sum_o, e.sum);
            check("sb_count", 32'(count_o), 32'(e.cnt));
            check("sb_ovf", 32'(ovf_o), 32'(e.ovf));
         end
      end
   end

   task automatic wait_ready();
      int unsigned k = 0;
      while (!ready_o && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
   endtask

   task automatic beat(input logic [15:0] op, input logic last);
      wait_ready();
      valid_i = 1'b1;
      op_i    = op;
      last_i  = last;
      @(posedge clk); #1;
      valid_i = 1'b0;
      last_i  = 1'b0;
   endtask

   task automatic send_row(input vec_t v);
      for (int i = 0; i < v.n; i++) begin
         if (i == v.n - 1) sb.push_back(v.res);
         beat(v.ops[i], i == v.n - 1);
      end
      check("latency_valid", 32'(sum_valid_o), 32'd1);
   endtask

   initial begin
      logic [31:0] sat_sum;
`ifdef EXPU_ACC_SATURATE_EN
      sat_sum = 32'hFFFF_FFFF;
`else
      sat_sum = 32'h0000_0000;
`endif
      tbl[0] = mk(16'h3F80, 16'h3F80, 16'h3F00, 16'h0, 3, 32'h0002_8000, 16'd3, 1'b0);
      tbl[1] = mk(16'h0000, 16'h0001, 16'h0, 16'h0, 2, 32'h0000_0000, 16'd2, 1'b0);
      tbl[2] = mk(16'h3380, 16'h0, 16'h0, 16'h0, 1, 32'h0000_0000, 16'd1, 1'b0);
      tbl[3] = mk(16'h4700, 16'h4700, 16'h0, 16'h0, 2, sat_sum, 16'd2, 1'b1);
      tbl[4] = mk(16'h7F80, 16'h0, 16'h0, 16'h0, 1, 32'hFFFF_FFFF, 16'd1, 1'b1);
      tbl[5] = mk(16'h4000, 16'h3E80, 16'h0, 16'h0, 2, 32'h0002_4000, 16'd2, 1'b0);
      tbl[6] = mk(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 4, 32'h0004_0000, 16'd4, 1'b0);
      tbl[7] = mk(16'h3FC0, 16'h3A81, 16'h0, 16'h0, 2, 32'h0001_8040, 16'd2, 1'b0);
      tbl[8] = mk(16'h4780, 16'h0, 16'h0, 16'h0, 1, 32'hFFFF_FFFF, 16'd1, 1'b1);
      tbl[9] = mk(16'h4680, 16'h4680, 16'h0, 16'h0, 2, 32'h8000_0000, 16'd2, 1'b0);

      rst_i = 1'b1; clear_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
      op_i = '0; sum_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      #1;
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_sum_valid", 32'(sum_valid_o), 32'd0);
      check("rst_sum", sum_o, 32'd0);
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_ovf", 32'(ovf_o), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) send_row(tbl[i]);

      // Result held while downstream stalls.
      wait_ready();
      sum_ready_i = 1'b0;
      send_row(mk(16'h3F80, 16'h0, 16'h0, 16'h0, 1, 32'h0001_0000, 16'd1, 1'b0));
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 32'(sum_valid_o), 32'd1);
         check("hold_ready", 32'(ready_o), 32'd0);
         check("hold_sum", sum_o, 32'h0001_0000);
         @(posedge clk); #1;
      end
      sum_ready_i = 1'b1;
      @(posedge clk); #1;
      check("post_hold_ready", 32'(ready_o), 32'd1);
      check("post_hold_valid", 32'(sum_valid_o), 32'd0);

      // Clear mid-row drops the partial sum and the coincident beat.
      beat(16'h3F80, 1'b0);
      beat(16'h3F80, 1'b0);
      check("pre_clear_count", 32'(count_o), 32'd2);
      clear_i = 1'b1; valid_i = 1'b1; op_i = 16'h3F80; last_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
      check("clear_count", 32'(count_o), 32'd0);
      check("clear_valid", 32'(sum_valid_o), 32'd0);
      send_row(mk(16'h3F00, 16'h0, 16'h0, 16'h0, 1, 32'h0000_8000, 16'd1, 1'b0));
      @(posedge clk); #1;

      // Async reset while holding a result.
      wait_ready();
      sum_ready_i = 1'b0;
      beat(16'h4000, 1'b1);
      check("rst_hold_valid_before", 32'(sum_valid_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("rst_hold_valid", 32'(sum_valid_o), 32'd0);
      check("rst_hold_ready", 32'(ready_o), 32'd1);
      @(posedge clk); #1;
      rst_i = 1'b0;
      sum_ready_i = 1'b1;

      repeat (3) @(posedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
